raster_tri_zbuf_p: RTL and testbench

//  Parametrised scan-conversion engine: walks a triangle's bounding box, tests each pixel against

---
 rtl/raster_tri_zbuf_p.sv | 268 ++++++++++++++++++++++++++
 tb/tb_raster_tri_zbuf_p.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_tri_zbuf_p.sv
// Triangle scan-conversion engine: walks a clipped bounding box with incremental edge equations,
// interpolates depth barycentrically, depth-tests against the z-buffer and writes colour and depth.
module raster_tri_zbuf_p #(
    parameter int unsigned SCR_W    = 320,
    parameter int unsigned SCR_H    = 240,
    parameter int unsigned XW       = 9,
    parameter int unsigned YW       = 8,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned CW       = 10,
    parameter int unsigned CCW      = 18,
    parameter int unsigned EW       = 22,
    parameter int unsigned ZW       = 8,
    parameter int unsigned COLOR_W  = 8,
    parameter int unsigned INV_FRAC = 24,
    parameter int unsigned CNT_W    = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    input  logic signed [CW-1:0]      i_a1,
    input  logic signed [CW-1:0]      i_a2,
    input  logic signed [CW-1:0]      i_a3,
    input  logic signed [CW-1:0]      i_b1,
    input  logic signed [CW-1:0]      i_b2,
    input  logic signed [CW-1:0]      i_b3,
    input  logic signed [CCW-1:0]     i_c1,
    input  logic signed [CCW-1:0]     i_c2,
    input  logic signed [CCW-1:0]     i_c3,
    input  logic [XW-1:0]             i_bbxi,
    input  logic [XW-1:0]             i_bbxf,
    input  logic [YW-1:0]             i_bbyi,
    input  logic [YW-1:0]             i_bbyf,
    input  logic [ZW-1:0]             i_z1,
    input  logic [ZW-1:0]             i_z2,
    input  logic [ZW-1:0]             i_z3,
    input  logic [31:0]               i_inv_area,
    input  logic [COLOR_W-1:0]        i_color,
    input  logic [1:0]                i_depth_func,
    input  logic                      i_zwrite_en,
    output logic                      o_fb_we,
    output logic [ADDR_W-1:0]         o_fb_addr,
    output logic [COLOR_W-1:0]        o_fb_din,
    output logic                      o_zb_en,
    output logic                      o_zb_we,
    output logic [ADDR_W-1:0]         o_zb_addr,
    output logic [ZW-1:0]             o_zb_din,
    input  logic [ZW-1:0]             i_zb_dout,
    output logic [CNT_W-1:0]          o_pix_count
);

    localparam int unsigned WW = EW + 33;       // edge * inv_area
    localparam int unsigned PW = WW + ZW + 1;   // weight * depth
    localparam int unsigned SW = PW + 2;        // sum of three products
    localparam logic [XW-1:0] XMAX = XW'(SCR_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(SCR_H - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP_MUL, S_SETUP_SUM, S_ROW, S_TEST, S_BARY, S_ZMUL,
        S_ZSUM, S_ADDR, S_ZRD, S_WR, S_STEP, S_NEXTROW, S_DONE
    } state_t;

    state_t r_state;

    logic signed [CW-1:0]  r_a [3];
    logic signed [CW-1:0]  r_b [3];
    logic signed [CCW-1:0] r_c [3];
    logic [ZW-1:0]         r_z [3];
    logic signed [EW-1:0]  r_ax [3];
    logic signed [EW-1:0]  r_by [3];
    logic signed [EW-1:0]  r_e [3];
    logic signed [EW-1:0]  r_er [3];
    logic signed [WW-1:0]  r_w [3];
    logic signed [PW-1:0]  r_p [3];
    logic [XW-1:0]         r_x0, r_xf, r_x;
    logic [YW-1:0]         r_yf, r_y;
    logic [31:0]           r_inv;
    logic [COLOR_W-1:0]    r_color;
    logic [1:0]            r_df;
    logic                  r_zwe, r_empty;
    logic [ZW-1:0]         r_zs;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_busy, r_done, r_fb_we, r_zb_en, r_zb_we;
    logic [COLOR_W-1:0]    r_fb_din;
    logic [ZW-1:0]         r_zb_din;
    logic [CNT_W-1:0]      r_pix;

    logic [XW-1:0]         w_xf;
    logic [YW-1:0]         w_yf;
    logic signed [SW-1:0]  w_zsum;
    logic [ZW-1:0]         w_zclamp;
    logic                  w_pass;
    logic                  w_inside;

    assign w_xf = (i_bbxf > XMAX) ? XMAX : i_bbxf;
    assign w_yf = (i_bbyf > YMAX) ? YMAX : i_bbyf;
    assign w_zsum = (SW'(r_p[0]) + SW'(r_p[1]) + SW'(r_p[2])) >>> INV_FRAC;
    assign w_inside = !r_er[0][EW-1] && !r_er[1][EW-1] && !r_er[2][EW-1];

    // Clamp interpolated depth into [0, 2^ZW-1]
    always_comb begin
        w_zclamp = w_zsum[ZW-1:0];
        if (w_zsum[SW-1])
            w_zclamp = '0;
        else if (|w_zsum[SW-2:ZW])
            w_zclamp = '1;
    end

    always_comb begin
        w_pass = 1'b0;
        case (r_df)
            2'b00:   w_pass = 1'b1;
            2'b01:   w_pass = r_zs <  i_zb_dout;
            2'b10:   w_pass = r_zs <= i_zb_dout;
            default: w_pass = r_zs >  i_zb_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fb_we  <= 1'b0;
            r_zb_en  <= 1'b0;
            r_zb_we  <= 1'b0;
            r_fb_din <= '0;
            r_zb_din <= '0;
            r_addr   <= '0;
            r_pix    <= '0;
            r_x0     <= '0;
            r_xf     <= '0;
            r_x      <= '0;
            r_yf     <= '0;
            r_y      <= '0;
            r_inv    <= '0;
            r_color  <= '0;
            r_df     <= '0;
            r_zwe    <= 1'b0;
            r_empty  <= 1'b0;
            r_zs     <= '0;
            for (int i = 0; i < 3; i++) begin
                r_a[i] <= '0; r_b[i] <= '0; r_c[i] <= '0; r_z[i] <= '0;
                r_ax[i] <= '0; r_by[i] <= '0; r_e[i] <= '0; r_er[i] <= '0;
                r_w[i] <= '0; r_p[i] <= '0;
            end
        end else begin
            r_done  <= 1'b0;
            r_fb_we <= 1'b0;
            r_zb_we <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_a[0] <= i_a1; r_a[1] <= i_a2; r_a[2] <= i_a3;
                    r_b[0] <= i_b1; r_b[1] <= i_b2; r_b[2] <= i_b3;
                    r_c[0] <= i_c1; r_c[1] <= i_c2; r_c[2] <= i_c3;
                    r_z[0] <= i_z1; r_z[1] <= i_z2; r_z[2] <= i_z3;
                    r_x0    <= i_bbxi;
                    r_xf    <= w_xf;
                    r_y     <= i_bbyi;
                    r_yf    <= w_yf;
                    r_empty <= (i_bbxi > w_xf) || (i_bbyi > w_yf);
                    r_inv   <= i_inv_area;
                    r_color <= i_color;
                    r_df    <= i_depth_func;
                    r_zwe   <= i_zwrite_en;
                    r_pix   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= S_SETUP_MUL;
                end
                S_SETUP_MUL: begin
                    for (int i = 0; i < 3; i++) begin
                        r_ax[i] <= EW'(r_a[i]) * EW'($signed({1'b0, r_x0}));
                        r_by[i] <= EW'(r_b[i]) * EW'($signed({1'b0, r_y}));
                    end
                    if (r_empty) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SETUP_SUM;
                    end
                end
                S_SETUP_SUM: begin
                    for (int i = 0; i < 3; i++)
                        r_e[i] <= r_ax[i] + r_by[i] + EW'(r_c[i]);
                    r_state <= S_ROW;
                end
                S_ROW: begin
                    r_x <= r_x0;
                    for (int i = 0; i < 3; i++)
                        r_er[i] <= r_e[i];
                    r_state <= S_TEST;
                end
                S_TEST: r_state <= w_inside ? S_BARY : S_STEP;
                S_BARY: begin
                    for (int i = 0; i < 3; i++)
                        r_w[i] <= WW'(r_er[i]) * WW'($signed({1'b0, r_inv}));
                    r_state <= S_ZMUL;
                end
                S_ZMUL: begin
                    for (int i = 0; i < 3; i++)
                        r_p[i] <= PW'(r_w[i]) * PW'($signed({1'b0, r_z[i]}));
                    r_state <= S_ZSUM;
                end
                S_ZSUM: begin
                    r_zs    <= w_zclamp;
                    r_state <= S_ADDR;
                end
                S_ADDR: begin
                    r_addr  <= ADDR_W'(r_y) * ADDR_W'(SCR_W) + ADDR_W'(r_x);
                    r_zb_en <= 1'b1;
                    r_state <= S_ZRD;
                end
                S_ZRD: r_state <= S_WR;
                // z-buffer read data is valid here, one cycle after the address
                S_WR: begin
                    if (w_pass) begin
                        r_fb_we  <= 1'b1;
                        r_fb_din <= r_color;
                        r_zb_we  <= r_zwe;
                        r_zb_din <= r_zs;
                        if (r_pix != '1)
                            r_pix <= r_pix + CNT_W'(1);
                    end
                    r_state <= S_STEP;
                end
                S_STEP: begin
                    r_zb_en <= 1'b0;
                    if (r_x == r_xf) begin
                        r_state <= S_NEXTROW;
                    end else begin
                        r_x <= r_x + XW'(1);
                        for (int i = 0; i < 3; i++)
                            r_er[i] <= r_er[i] + EW'(r_a[i]);
                        r_state <= S_TEST;
                    end
                end
                S_NEXTROW: begin
                    if (r_y == r_yf) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_y <= r_y + YW'(1);
                        for (int i = 0; i < 3; i++)
                            r_e[i] <= r_e[i] + EW'(r_b[i]);
                        r_state <= S_ROW;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_fb_we     = r_fb_we;
    assign o_fb_addr   = r_addr;
    assign o_fb_din    = r_fb_din;
    assign o_zb_en     = r_zb_en;
    assign o_zb_we     = r_zb_we;
    assign o_zb_addr   = r_addr;
    assign o_zb_din    = r_zb_din;
    assign o_pix_count = r_pix;

endmodule

// File: tb/tb_raster_tri_zbuf_p.sv
// Self-checking bench for raster_tri_zbuf_p: scoreboard of expected pixel writes, per-scenario tasks.
module tb_raster_tri_zbuf_p;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, fb_we, zb_en, zb_we;
    logic signed [9:0]  a1, a2, a3, b1, b2, b3;
    logic signed [17:0] c1, c2, c3;
    logic [8:0]  bbxi, bbxf;
    logic [7:0]  bbyi, bbyf;
    logic [7:0]  z1, z2, z3;
    logic [31:0] inv_area;
    logic [7:0]  color;
    logic [1:0]  depth_func;
    logic        zwrite_en;
    logic [16:0] fb_addr, zb_addr;
    logic [7:0]  fb_din, zb_din, zb_dout;
    logic [16:0] pix_count;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  color;
        logic        zwe;
        logic [7:0]  z;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  n_wr = 0;
    int  n_done = 0;
    int  n_busy = 0;
    logic [16:0] last_addr = '0;

    always #5 clk = ~clk;

    raster_tri_zbuf_p dut (
        .clk(clk), .rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
        .i_a1(a1), .i_a2(a2), .i_a3(a3), .i_b1(b1), .i_b2(b2), .i_b3(b3),
        .i_c1(c1), .i_c2(c2), .i_c3(c3),
        .i_bbxi(bbxi), .i_bbxf(bbxf), .i_bbyi(bbyi), .i_bbyf(bbyf),
        .i_z1(z1), .i_z2(z2), .i_z3(z3), .i_inv_area(inv_area), .i_color(color),
        .i_depth_func(depth_func), .i_zwrite_en(zwrite_en),
        .o_fb_we(fb_we), .o_fb_addr(fb_addr), .o_fb_din(fb_din),
        .o_zb_en(zb_en), .o_zb_we(zb_we), .o_zb_addr(zb_addr), .o_zb_din(zb_din),
        .i_zb_dout(zb_dout), .o_pix_count(pix_count)
    );

    // Scoreboard: every frame-buffer strobe pops one expected write
    always @(negedge clk) begin
        if (busy) n_busy++;
        if (done) n_done++;
        if (fb_we) begin
            n_wr++;
            last_addr = fb_addr;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d din=%0d", fb_addr, fb_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({fb_addr, zb_addr, fb_din, zb_we, zb_din, zb_en} !==
                    {e.addr, e.addr, e.color, e.zwe, e.z, 1'b1}) begin
                    errors++;
                    $display("FAIL write got addr=%0d/%0d din=%0d zwe=%0d z=%0d zen=%0d want addr=%0d din=%0d zwe=%0d z=%0d",
                             fb_addr, zb_addr, fb_din, zb_we, zb_din, zb_en, e.addr, e.color, e.zwe, e.z);
                end
            end
        end else if (zb_we) begin
            checks++;
            errors++;
            $display("FAIL zb_we_without_fb_we addr=%0d", zb_addr);
        end
    end

    task automatic clear_tri();
        a1 = '0; a2 = '0; a3 = '0; b1 = '0; b2 = '0; b3 = '0;
        c1 = '0; c2 = '0; c3 = '0;
        bbxi = '0; bbxf = '0; bbyi = '0; bbyf = '0;
        z1 = '0; z2 = '0; z3 = '0;
        inv_area = 32'h0100_0000; color = 8'h00;
        depth_func = 2'b00; zwrite_en = 1'b1; zb_dout = 8'hFF;
    endtask

    task automatic set_t1();
        clear_tri();
        c1 = 18'sd1; bbxi = 9'd5; bbxf = 9'd5; bbyi = 8'd5; bbyf = 8'd5;
        z1 = 8'd10; color = 8'hA5; depth_func = 2'b01; zb_dout = 8'd255;
    endtask

    task automatic set_t3();
        clear_tri();
        b1 = 10'sd1; a2 = 10'sd1; a3 = -10'sd1; b3 = -10'sd1; c3 = 18'sd4;
        bbxf = 9'd4; bbyf = 8'd4;
        z1 = 8'd40; z2 = 8'd80; z3 = 8'd120;
        inv_area = 32'h0040_0000; color = 8'h3C;
    endtask

    // Triangle 3: depth = (y*z1 + x*z2 + (4-x-y)*z3) / 4 = 120 - 10x - 20y
    task automatic push_t3();
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4; x++)
                if (x + y <= 4)
                    exp_q.push_back('{addr: 17'(y * 320 + x), color: 8'h3C, zwe: 1'b1,
                                      z: 8'(120 - 10 * x - 20 * y)});
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_tri();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, fb_we, zb_en, zb_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b want=00000", {busy, done, fb_we, zb_en, zb_we});
        end
        checks++;
        if ({pix_count, fb_addr, zb_addr, fb_din, zb_din} !== '0) begin
            errors++;
            $display("FAIL reset_data pix=%0d fa=%0d za=%0d fd=%0d zd=%0d want all 0",
                     pix_count, fb_addr, zb_addr, fb_din, zb_din);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int w0, d0, b0;
        bit ok;
        set_t1();
        exp_q.push_back('{addr: 17'd1605, color: 8'hA5, zwe: 1'b1, z: 8'd10});
        w0 = n_wr; d0 = n_done; b0 = n_busy;
        launch();
        wait_done(100, ok);
        @(negedge clk);
        checks++;
        if (!ok || (n_wr - w0) != 1 || (n_done - d0) != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single ok=%0d writes=%0d dones=%0d left=%0d want 1/1/1/0",
                     ok, n_wr - w0, n_done - d0, exp_q.size());
        end
        checks++;
        if (pix_count !== 17'd1 || (n_busy - b0) != 12) begin
            errors++;
            $display("FAIL single_count pix=%0d busy_cyc=%0d want 1/12", pix_count, n_busy - b0);
        end
        exp_q.delete();
    endtask

    task automatic test_depth();
        logic [1:0] df_t [5]  = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
        logic [7:0] zd_t [5]  = '{8'd10, 8'd10, 8'd5, 8'd10, 8'd0};
        logic       zwe_t [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       pass_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            int w0;
            bit ok;
            set_t1();
            depth_func = df_t[k]; zb_dout = zd_t[k]; zwrite_en = zwe_t[k];
            if (pass_t[k])
                exp_q.push_back('{addr: 17'd1605, color: 8'hA5, zwe: zwe_t[k], z: 8'd10});
            w0 = n_wr;
            launch();
            wait_done(100, ok);
            checks++;
            if (!ok || (n_wr - w0) != int'(pass_t[k]) || pix_count !== 17'(pass_t[k]) || exp_q.size() != 0) begin
                errors++;
                $display("FAIL depth_case%0d ok=%0d writes=%0d pix=%0d want writes=pix=%0d",
                         k, ok, n_wr - w0, pix_count, pass_t[k]);
            end
            exp_q.delete();
        end
    endtask

    task automatic test_triangle();
        int w0, b0;
        bit ok;
        set_t3();
        push_t3();
        w0 = n_wr; b0 = n_busy;
        launch();
        wait_done(400, ok);
        checks++;
        if (!ok || (n_wr - w0) != 15 || exp_q.size() != 0 || pix_count !== 17'd15) begin
            errors++;
            $display("FAIL triangle ok=%0d writes=%0d left=%0d pix=%0d want 15 writes",
                     ok, n_wr - w0, exp_q.size(), pix_count);
        end
        checks++;
        if ((n_busy - b0) != 152) begin
            errors++;
            $display("FAIL triangle_cycles got=%0d want=152", n_busy - b0);
        end
        exp_q.delete();
    endtask

    task automatic test_clip();
        int w0, b0;
        bit ok;
        clear_tri();
        c1 = 18'sd1; bbxi = 9'd315; bbxf = 9'd400; bbyi = 8'd3; bbyf = 8'd3;
        z1 = 8'd10; color = 8'h77;
        for (int x = 315; x <= 319; x++)
            exp_q.push_back('{addr: 17'(3 * 320 + x), color: 8'h77, zwe: 1'b1, z: 8'd10});
        w0 = n_wr; b0 = n_busy;
        launch();
        wait_done(200, ok);
        checks++;
        if (!ok || (n_wr - w0) != 5 || last_addr !== 17'd1279 || (n_busy - b0) != 44) begin
            errors++;
            $display("FAIL clip_x ok=%0d writes=%0d last=%0d busy=%0d want 5/1279/44",
                     ok, n_wr - w0, last_addr, n_busy - b0);
        end
        exp_q.delete();
        clear_tri();
        c1 = 18'sd1; bbxi = 9'd0; bbxf = 9'd4; bbyi = 8'd10; bbyf = 8'd5;
        w0 = n_wr;
        launch();
        wait_done(3, ok);
        checks++;
        if (!ok || (n_wr - w0) != 0 || pix_count !== 17'd0) begin
            errors++;
            $display("FAIL empty_box ok=%0d writes=%0d pix=%0d want done/0/0", ok, n_wr - w0, pix_count);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int w0, b0, d0;
        bit ok;
        set_t3();
        push_t3();
        w0 = n_wr; b0 = n_busy; d0 = n_done;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            start = 1'b1;
            {a1, a2, a3} = 30'($urandom);
            {b1, b2, b3} = 30'($urandom);
            {c1, c2} = 36'({$urandom, $urandom});
            c3 = 18'($urandom);
            {bbxi, bbxf, bbyi, bbyf} = 34'({$urandom, $urandom});
            {z1, z2, z3, color} = $urandom;
            inv_area = $urandom;
            {depth_func, zwrite_en, zb_dout} = 11'($urandom);
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        set_t3();
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || (n_wr - w0) != 15 || exp_q.size() != 0 || (n_busy - b0) != 152 || (n_done - d0) != 1) begin
            errors++;
            $display("FAIL back_to_back ok=%0d writes=%0d left=%0d busy=%0d dones=%0d want 15/0/152/1",
                     ok, n_wr - w0, exp_q.size(), n_busy - b0, n_done - d0);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int w0, d0;
        set_t3();
        push_t3();
        launch();
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, fb_we, zb_we, zb_en} !== 5'b0 || pix_count !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid got=%b pix=%0d want 00000/0", {busy, done, fb_we, zb_we, zb_en}, pix_count);
        end
        rst = 1'b0;
        exp_q.delete();
        w0 = n_wr; d0 = n_done;
        repeat (200) @(negedge clk);
        checks++;
        if ((n_wr - w0) != 0 || (n_done - d0) != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon writes=%0d dones=%0d busy=%0d want 0/0/0", n_wr - w0, n_done - d0, busy);
        end
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_depth();
        test_triangle();
        test_clip();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
